// File: rtl/pong_text_writer.sv
// Command-driven text writer for the Pong score/status line: a small FSM fills an
// 8-bit character buffer. Optional double buffering via PONG_TEXT_DOUBLE_BUFFER_EN.
module pong_text_writer #(
  parameter int unsigned c_MAX_STR_LEN = 15,
  parameter int unsigned c_POS_WIDTH   = 4
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_n,
  input  logic                       i_Cmd_Valid,
  output logic                       o_Cmd_Ready,
  input  logic [1:0]                 i_Cmd,
  input  logic [c_POS_WIDTH-1:0]     i_Pos,
  input  logic [7:0]                 i_Char,
  input  logic [6:0]                 i_Value,
  input  logic                       i_Frame_Strobe,
  output logic [c_MAX_STR_LEN*8-1:0] o_DisplayStr,
  output logic                       o_Busy,
  output logic                       o_Done
);

  // One extra index bit so that pos+1 past the last cell cannot wrap onto cell 0.
  localparam int unsigned IDX_W = c_POS_WIDTH + 1;
  localparam int unsigned STR_W = c_MAX_STR_LEN * 8;

  localparam logic [7:0] SPACE     = 8'h20;
  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [6:0] SCORE_MAX = 7'd99;
  localparam logic [6:0] TEN       = 7'd10;
  localparam logic [6:0] TWENTY    = 7'd20;

  typedef enum logic [1:0] {
    OP_CLEAR     = 2'b00,
    OP_PUT_CHAR  = 2'b01,
    OP_PUT_SCORE = 2'b10,
    OP_RSVD      = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DIV,
    S_WR_TENS,
    S_WR_ONES,
    S_DONE
  } state_e;

  state_e             state_q, state_n;
  op_e                op_q;
  logic [IDX_W-1:0]   pos_q;
  logic [IDX_W-1:0]   clr_idx_q;
  logic [7:0]         char_q;
  logic [6:0]         rem_q;
  logic [3:0]         tens_q;
  logic [STR_W-1:0]   back_q;

  logic               accept_c;
  logic [6:0]         sat_value_c;
  logic               wr_en_c;
  logic [IDX_W-1:0]   wr_idx_c;
  logic [7:0]         wr_data_c;

  assign accept_c    = i_Cmd_Valid & o_Cmd_Ready;
  assign sat_value_c = (i_Value > SCORE_MAX) ? SCORE_MAX : i_Value;

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state and buffer write port
  always_comb begin
    state_n   = state_q;
    wr_en_c   = 1'b0;
    wr_idx_c  = '0;
    wr_data_c = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          case (op_e'(i_Cmd))
            OP_CLEAR:     state_n = S_CLEAR;
            OP_PUT_CHAR:  state_n = S_WR_TENS;
            OP_PUT_SCORE: state_n = (sat_value_c >= TEN) ? S_DIV : S_WR_TENS;
            default:      state_n = S_DONE;
          endcase
        end
      end
      S_CLEAR: begin
        wr_en_c   = 1'b1;
        wr_idx_c  = clr_idx_q;
        wr_data_c = SPACE;
        if (clr_idx_q == IDX_W'(c_MAX_STR_LEN - 1)) begin
          state_n = S_DONE;
        end
      end
      S_DIV: begin
        // Leave once this subtraction brings the remainder below ten.
        if (rem_q < TWENTY) begin
          state_n = S_WR_TENS;
        end
      end
      S_WR_TENS: begin
        wr_en_c   = 1'b1;
        wr_idx_c  = pos_q;
        wr_data_c = (op_q == OP_PUT_CHAR) ? char_q : ASCII_0 + 8'(tens_q);
        state_n   = (op_q == OP_PUT_CHAR) ? S_DONE : S_WR_ONES;
      end
      S_WR_ONES: begin
        wr_en_c   = 1'b1;
        wr_idx_c  = pos_q + IDX_W'(1);
        wr_data_c = ASCII_0 + 8'(rem_q);
        state_n   = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Captured command fields and divide/clear working registers
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      op_q      <= OP_CLEAR;
      pos_q     <= '0;
      char_q    <= '0;
      rem_q     <= '0;
      tens_q    <= '0;
      clr_idx_q <= '0;
    end else if (accept_c) begin
      op_q      <= op_e'(i_Cmd);
      pos_q     <= {1'b0, i_Pos};
      char_q    <= i_Char;
      rem_q     <= sat_value_c;
      tens_q    <= '0;
      clr_idx_q <= '0;
    end else begin
      if (state_q == S_DIV) begin
        rem_q  <= rem_q - TEN;
        tens_q <= tens_q + 4'd1;
      end
      if (state_q == S_CLEAR) begin
        clr_idx_q <= clr_idx_q + IDX_W'(1);
      end
    end
  end

  // Back buffer; an index beyond the last cell matches no cell, so the write is dropped.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      back_q <= {c_MAX_STR_LEN{SPACE}};
    end else begin
      for (int k = 0; k < c_MAX_STR_LEN; k++) begin
        if (wr_en_c && (wr_idx_c == IDX_W'(k))) begin
          back_q[k*8 +: 8] <= wr_data_c;
        end
      end
    end
  end

  // Handshake/status flags track the state being entered
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Cmd_Ready <= 1'b1;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
    end else begin
      o_Cmd_Ready <= (state_n == S_IDLE);
      o_Busy      <= (state_n != S_IDLE);
      o_Done      <= (state_n == S_DONE);
    end
  end

`ifdef PONG_TEXT_DOUBLE_BUFFER_EN
  logic [STR_W-1:0] front_q;
  logic             pending_q;
  logic             pending_c;

  assign pending_c = pending_q | i_Frame_Strobe;

  // Publish only between commands so a half-written update is never shown.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      front_q   <= {c_MAX_STR_LEN{SPACE}};
      pending_q <= 1'b0;
    end else if (pending_c && (state_q == S_IDLE)) begin
      front_q   <= back_q;
      pending_q <= 1'b0;
    end else if (i_Frame_Strobe) begin
      pending_q <= 1'b1;
    end
  end

  assign o_DisplayStr = front_q;
`else
  logic unused_frame_strobe;
  assign unused_frame_strobe = i_Frame_Strobe;
  assign o_DisplayStr        = back_q;
`endif

endmodule

// File: tb/tb_pong_text_writer.sv
// Scoreboard bench for pong_text_writer: random commands against a cell-array model,
// checked at every o_Done for latency and displayed string.
module tb_pong_text_writer;

  localparam int MAX = 15;
  localparam int PW  = 4;
  localparam int SW  = MAX * 8;

  logic          i_Clk          = 1'b0;
  logic          i_Rst_n        = 1'b1;
  logic          i_Cmd_Valid    = 1'b0;
  logic          o_Cmd_Ready;
  logic [1:0]    i_Cmd          = 2'd0;
  logic [PW-1:0] i_Pos          = '0;
  logic [7:0]    i_Char         = 8'd0;
  logic [6:0]    i_Value        = 7'd0;
  logic          i_Frame_Strobe = 1'b0;
  logic [SW-1:0] o_DisplayStr;
  logic          o_Busy;
  logic          o_Done;

  pong_text_writer #(.c_MAX_STR_LEN(MAX), .c_POS_WIDTH(PW)) dut (
    .i_Clk          (i_Clk),
    .i_Rst_n        (i_Rst_n),
    .i_Cmd_Valid    (i_Cmd_Valid),
    .o_Cmd_Ready    (o_Cmd_Ready),
    .i_Cmd          (i_Cmd),
    .i_Pos          (i_Pos),
    .i_Char         (i_Char),
    .i_Value        (i_Value),
    .i_Frame_Strobe (i_Frame_Strobe),
    .o_DisplayStr   (o_DisplayStr),
    .o_Busy         (o_Busy),
    .o_Done         (o_Done)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int            lat;
    logic [SW-1:0] disp;
    string         name;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] back_m  [MAX];
  logic [7:0] front_m [MAX];
  int         checks = 0;
  int         errors = 0;

  function automatic logic [SW-1:0] expected_disp();
    logic [SW-1:0] v;
    for (int k = 0; k < MAX; k++) begin
`ifdef PONG_TEXT_DOUBLE_BUFFER_EN
      v[k*8 +: 8] = front_m[k];
`else
      v[k*8 +: 8] = back_m[k];
`endif
    end
    return v;
  endfunction

  task automatic check_val(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < MAX; k++) begin
      back_m[k]  = 8'h20;
      front_m[k] = 8'h20;
    end
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    @(negedge i_Clk);
    while (!o_Cmd_Ready && n < 200) begin
      @(negedge i_Clk);
      n++;
    end
    ok = o_Cmd_Ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: o_Cmd_Ready=%0b expected 1 within 200 cycles", o_Cmd_Ready);
    end
  endtask

  // Apply the command to the model, queue its expected completion, then drive it.
  task automatic issue(input logic [1:0] c, input int pos, input logic [7:0] ch, input int val);
    exp_t e;
    bit   ok;
    int   v;
    wait_ready(ok);
    if (!ok) return;
    case (c)
      2'd0: begin
        for (int k = 0; k < MAX; k++) back_m[k] = 8'h20;
        e.lat = 16;
      end
      2'd1: begin
        if (pos < MAX) back_m[pos] = ch;
        e.lat = 2;
      end
      2'd2: begin
        v = (val > 99) ? 99 : val;
        if (pos < MAX)     back_m[pos]     = 8'(48 + v / 10);
        if (pos + 1 < MAX) back_m[pos + 1] = 8'(48 + v % 10);
        e.lat = v / 10 + 3;
      end
      default: e.lat = 1;
    endcase
    e.disp = expected_disp();
    e.name = $sformatf("op%0d_pos%0d_val%0d", c, pos, val);
    sb.push_back(e);
    i_Cmd       = c;
    i_Pos       = PW'(pos);
    i_Char      = ch;
    i_Value     = 7'(val);
    i_Cmd_Valid = 1'b1;
    @(posedge i_Clk);
    #1;
    i_Cmd_Valid = 1'b0;
    i_Cmd       = 2'($urandom);
    i_Pos       = PW'($urandom);
    i_Char      = 8'($urandom);
    i_Value     = 7'($urandom);
  endtask

  task automatic pulse_strobe();
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    i_Frame_Strobe = 1'b1;
    @(posedge i_Clk);
    #1;
    i_Frame_Strobe = 1'b0;
`ifdef PONG_TEXT_DOUBLE_BUFFER_EN
    for (int k = 0; k < MAX; k++) front_m[k] = back_m[k];
`endif
    @(negedge i_Clk);
    check_val("strobe_display", o_DisplayStr, expected_disp());
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(negedge i_Clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d completions outstanding, expected 0", sb.size());
    end
  endtask

  // Monitor: counts busy cycles and scores each completion against the queue.
  initial begin
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge i_Clk);
      if (!i_Rst_n) begin
        busy_cnt = 0;
      end else begin
        if (o_Busy) busy_cnt++;
        if (o_Done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: o_Done=1 with no command outstanding, expected 0");
          end else begin
            e = sb.pop_front();
            check_val({e.name, "_latency"}, SW'(busy_cnt), SW'(e.lat));
            check_val({e.name, "_display"}, o_DisplayStr, e.disp);
            check_val({e.name, "_ready_in_done"}, SW'(o_Cmd_Ready), SW'(0));
          end
        end
        if (!o_Busy) busy_cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [1:0] c;
    model_reset();

    #1 i_Rst_n = 1'b0;
    #1;
    check_val("reset_ready", SW'(o_Cmd_Ready), SW'(1));
    check_val("reset_busy",  SW'(o_Busy),      SW'(0));
    check_val("reset_done",  SW'(o_Done),      SW'(0));
    check_val("reset_display", o_DisplayStr, expected_disp());
    #10 i_Rst_n = 1'b1;
    @(negedge i_Clk);
    check_val("post_reset_display", o_DisplayStr, expected_disp());
    check_val("post_reset_ready", SW'(o_Cmd_Ready), SW'(1));

    // Directed boundary cases
    issue(2'd1, 3, 8'h41, 0);
    issue(2'd2, 5, 8'h00, 47);
    issue(2'd2, 14, 8'h00, 120);
    issue(2'd1, 15, 8'h7a, 0);
    issue(2'd0, 0, 8'h00, 0);
    issue(2'd2, 0, 8'h00, 9);
    issue(2'd2, 7, 8'h00, 100);
    issue(2'd2, 10, 8'h00, 10);
    issue(2'd3, 2, 8'h55, 33);
    issue(2'd1, 0, 8'h50, 0);
    drain();
    pulse_strobe();

    // Random traffic with occasional frame strobes
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      c = (r == 0) ? 2'd0 : (r < 4) ? 2'd1 : (r < 8) ? 2'd2 : 2'd3;
      issue(c, $urandom_range(0, 15), 8'($urandom_range(33, 126)), $urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) begin
        drain();
        pulse_strobe();
      end
    end
    drain();
    pulse_strobe();

    // Abort a CLEAR with reset: no completion may follow
    issue(2'd1, 12, 8'h58, 0);
    drain();
    pulse_strobe();
    issue(2'd0, 0, 8'h00, 0);
    repeat (5) @(posedge i_Clk);
    #2 i_Rst_n = 1'b0;
    sb.delete();
    model_reset();
    #1;
    check_val("abort_ready", SW'(o_Cmd_Ready), SW'(1));
    check_val("abort_busy",  SW'(o_Busy),      SW'(0));
    check_val("abort_done",  SW'(o_Done),      SW'(0));
    check_val("abort_display", o_DisplayStr, expected_disp());
    repeat (2) @(negedge i_Clk);
    i_Rst_n = 1'b1;
    repeat (20) @(negedge i_Clk);
    issue(2'd2, 1, 8'h00, 63);
    drain();
    pulse_strobe();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
